// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-based request issue, in-order responses, decode queue.
// Optional FETCH_MISALIGN_TRAP_EN turns misaligned redirect targets into trap entries.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic            out_misaligned
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] q_pc [DEPTH];
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] pf_pc [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr, pf_rd, pf_wr;
    logic [CW-1:0]   count, outstanding;
    logic [SW-1:0]   stale;
    logic [XLEN-1:0] last_pc, last_instr;
    logic [XLEN-1:0] target, enq_pc, enq_instr;
    logic [CW:0]     inflight;
    logic            halted, trap_pend;
    logic            acc, live_rsp, enq, pop;

    assign inflight = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !reset && !halted && !trap_pend
                          && (inflight < (CW+1)'(DEPTH));
    assign imem_req_addr = fetch_pc;

    assign acc      = imem_req_valid && imem_req_ready;
    assign live_rsp = imem_rsp_valid && (stale == '0);
    assign enq      = (live_rsp || trap_pend) && !redirect_valid;
    assign pop      = out_valid && out_ready && !redirect_valid;

    assign enq_pc    = trap_pend ? fetch_pc : pf_pc[pf_rd];
    assign enq_instr = trap_pend ? '0 : imem_rsp_data;

    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? q_pc[rd_ptr] : last_pc;
    assign out_instr = out_valid ? q_instr[rd_ptr] : last_instr;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic q_mis [DEPTH];
    logic last_mis;

    assign target = redirect_pc;
    assign out_misaligned = out_valid ? q_mis[rd_ptr] : last_mis;

    always_ff @(posedge clk) begin
        if (enq)
            q_mis[wr_ptr] <= trap_pend;
    end

    // A misaligned target spends one cycle enqueuing its marker, then parks.
    always_ff @(posedge clk) begin
        if (reset) begin
            halted    <= 1'b0;
            trap_pend <= 1'b0;
            last_mis  <= 1'b0;
        end else begin
            if (out_valid)
                last_mis <= q_mis[rd_ptr];
            if (redirect_valid) begin
                halted    <= 1'b0;
                trap_pend <= |redirect_pc[1:0];
            end else if (trap_pend) begin
                trap_pend <= 1'b0;
                halted    <= 1'b1;
            end
        end
    end
`else
    logic unused_lo;

    assign unused_lo = ^redirect_pc[1:0];
    assign target = {redirect_pc[XLEN-1:2], 2'b00};
    assign out_misaligned = 1'b0;
    assign halted = 1'b0;
    assign trap_pend = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (acc && !redirect_valid)
            pf_pc[pf_wr] <= fetch_pc;
        if (enq) begin
            q_pc[wr_ptr]    <= enq_pc;
            q_instr[wr_ptr] <= enq_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pf_rd       <= '0;
            pf_wr       <= '0;
            count       <= '0;
            outstanding <= '0;
            stale       <= '0;
            last_pc     <= '0;
            last_instr  <= '0;
        end else begin
            if (out_valid) begin
                last_pc    <= q_pc[rd_ptr];
                last_instr <= q_instr[rd_ptr];
            end
            if (redirect_valid) begin
                // Everything still in flight, including this cycle's traffic, turns stale.
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                pf_rd       <= '0;
                pf_wr       <= '0;
                count       <= '0;
                outstanding <= '0;
                stale       <= stale + SW'(outstanding) + SW'(acc)
                             - SW'(imem_rsp_valid);
                fetch_pc    <= target;
            end else begin
                if (acc) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                    pf_wr    <= pf_wr + 1'b1;
                end
                if (imem_rsp_valid) begin
                    if (stale != '0)
                        stale <= stale - 1'b1;
                    else
                        pf_rd <= pf_rd + 1'b1;
                end
                outstanding <= outstanding + CW'(acc) - CW'(live_rsp);
                if (enq)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(enq) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(enq && count == CW'(DEPTH)));
            assert (!(imem_rsp_valid && stale == '0 && outstanding == '0));
        end
    end
endmodule
